// File: rtl/vec_alu_sequencer.sv
// Element-serial issue/writeback sequencer for the vector ALU.
// It accepts one vector instruction and streams its elements through three stages:
//   - Read: the VRF read is issued.
//   - ALU: operands go to the ALU.
//   - Write: the result is merged with old vd under the element mask and written back.
// One element moves through each stage per cycle.
//
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE and outside reset. All in_* fields are captured
// on that edge and are not looked at again until the next transfer.
module vec_alu_sequencer #(
  parameter int MAXVL = 32,
  localparam int EW = $clog2(MAXVL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_vd,
  input  logic [4:0]        in_vs1,
  input  logic [4:0]        in_vs2,
  input  logic              in_vm,
  input  logic [EW:0]       in_vl,
  input  logic [MAXVL-1:0]  in_mask,
  output logic              rf_ren,
  output logic [5+EW-1:0]   rf_raddr1,
  output logic [5+EW-1:0]   rf_raddr2,
  output logic [5+EW-1:0]   rf_raddr3,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  input  logic [31:0]       rf_rdata3,
  output logic [31:0]       alu_operand1,
  output logic [31:0]       alu_operand2,
  output logic [3:0]        alu_operation,
  output logic              alu_mask,
  input  logic [31:0]       alu_out,
  output logic              rf_we,
  output logic [5+EW-1:0]   rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [EW:0] VL_MAX = (EW+1)'(MAXVL);

  state_t state, state_nx;

  // Captured instruction fields.
  logic [3:0]       op_r;
  logic [4:0]       vd_r, vs1_r, vs2_r;
  logic             vm_r;
  logic [MAXVL-1:0] mask_r;
  logic [EW:0]      vl_r;

  // Pipeline: read index, ALU stage, write stage.
  logic [EW-1:0]    rd_idx;
  logic             a_valid;
  logic [EW-1:0]    a_idx;
  logic             w_valid;
  logic [EW-1:0]    w_idx;
  logic [31:0]      w_data;

  logic             accept;
  logic [EW:0]      vl_in_eff;
  logic             rd_last;
  logic             done_nx;
  logic             mask_eff;
  logic [31:0]      merged;

  assign in_ready  = (state == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign vl_in_eff = (in_vl > VL_MAX) ? VL_MAX : in_vl;
  assign rd_last   = ({1'b0, rd_idx} == (vl_r - (EW+1)'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and the done pulse request; the write stage is the last to empty.
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (vl_in_eff != '0)) state_nx = RUN;
        if (accept && (vl_in_eff == '0)) done_nx = 1'b1;
      end
      RUN: begin
        if (rd_last) state_nx = DRAIN;
      end
      DRAIN: begin
        // ALU stage empty means this cycle holds the final write.
        if (!a_valid) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Instruction capture, read index and pipeline stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r    <= '0;
      vd_r    <= '0;
      vs1_r   <= '0;
      vs2_r   <= '0;
      vm_r    <= 1'b0;
      mask_r  <= '0;
      vl_r    <= '0;
      rd_idx  <= '0;
      a_valid <= 1'b0;
      a_idx   <= '0;
      w_valid <= 1'b0;
      w_idx   <= '0;
      w_data  <= '0;
      done    <= 1'b0;
    end else begin
      if (accept) begin
        op_r   <= in_op;
        vd_r   <= in_vd;
        vs1_r  <= in_vs1;
        vs2_r  <= in_vs2;
        vm_r   <= in_vm;
        mask_r <= in_mask;
        vl_r   <= vl_in_eff;
        rd_idx <= '0;
      end else if (state == RUN) begin
        rd_idx <= rd_idx + EW'(1);
      end
      a_valid <= (state == RUN);
      a_idx   <= rd_idx;
      w_valid <= a_valid;
      w_idx   <= a_idx;
      w_data  <= a_valid ? merged : '0;
      done    <= done_nx;
    end
  end

  // Masked-off elements keep the old destination value.
  assign mask_eff = a_valid && (vm_r || mask_r[a_idx]);
  assign merged   = mask_eff ? alu_out : rf_rdata3;

  assign rf_ren    = (state == RUN);
  assign rf_raddr1 = rf_ren ? {vs1_r, rd_idx} : '0;
  assign rf_raddr2 = rf_ren ? {vs2_r, rd_idx} : '0;
  assign rf_raddr3 = rf_ren ? {vd_r,  rd_idx} : '0;

  assign alu_operand1  = a_valid ? rf_rdata1 : '0;
  assign alu_operand2  = a_valid ? rf_rdata2 : '0;
  assign alu_operation = a_valid ? op_r : '0;
  assign alu_mask      = mask_eff;

  assign rf_we    = w_valid;
  assign rf_waddr = w_valid ? {vd_r, w_idx} : '0;
  assign rf_wdata = w_data;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer. It provides a VRF model with a one-cycle
// read and an ALU model, plus a negedge monitor that logs activity relative to
// the latest accept.
module tb_vec_alu_sequencer;
  localparam int MAXVL = 32;
  localparam int EW = 5;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready;
  logic [3:0] in_op;
  logic [4:0] in_vd, in_vs1, in_vs2;
  logic in_vm;
  logic [EW:0] in_vl;
  logic [MAXVL-1:0] in_mask;
  logic rf_ren, rf_we, busy, done, alu_mask;
  logic [5+EW-1:0] rf_raddr1, rf_raddr2, rf_raddr3, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_rdata3, rf_wdata;
  logic [31:0] alu_operand1, alu_operand2, alu_out;
  logic [3:0] alu_operation;

  int checks = 0;
  int failures = 0;

  vec_alu_sequencer #(.MAXVL(MAXVL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_vm(in_vm), .in_vl(in_vl), .in_mask(in_mask),
    .rf_ren(rf_ren), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_raddr3(rf_raddr3), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_rdata3(rf_rdata3), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_operation(alu_operation),
    .alu_mask(alu_mask), .alu_out(alu_out), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .done(done)
  );

  // Clock.
  always #5 clk = ~clk;

  // VRF model: registered read, write on rf_we.
  logic [31:0] vrf [0:1023];
  always @(posedge clk) begin
    if (rf_ren) begin
      rf_rdata1 <= vrf[rf_raddr1];
      rf_rdata2 <= vrf[rf_raddr2];
      rf_rdata3 <= vrf[rf_raddr3];
    end
    if (rf_we) vrf[rf_waddr] = rf_wdata;
  end

  // ALU model.
  always_comb begin
    alu_out = 32'h0;
    case (alu_operation)
      4'd0: alu_out = alu_operand1 + alu_operand2;
      4'd1: alu_out = alu_operand1 - alu_operand2;
      4'd2: alu_out = alu_operand1 & alu_operand2;
      4'd7: alu_out = $signed(alu_operand1) >>> alu_operand2[4:0];
      default: alu_out = 32'h0;
    endcase
  end

  // Monitor.
  int cyc = 0;
  int acc_cyc = 0;
  int acc_count, ren_count, wr_count, done_count, first_wr, last_wr, done_rel;
  logic [5+EW-1:0] first_raddr1, first_raddr3, last_waddr;
  logic [63:0] mask_log;
  logic [3:0] op_seen;
  logic [31:0] opnd1_seen;
  int b2b_acc [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int rel;
    if (in_valid && in_ready) begin
      acc_cyc = cyc;
      acc_count++;
      b2b_acc.push_back(cyc);
    end
    rel = cyc - acc_cyc;
    if (rf_ren) begin
      ren_count++;
      if (rel == 1) begin
        first_raddr1 = rf_raddr1;
        first_raddr3 = rf_raddr3;
      end
    end
    if (rf_we) begin
      wr_count++;
      if (first_wr < 0) first_wr = rel;
      last_wr = rel;
      last_waddr = rf_waddr;
    end
    if (done) begin
      done_count++;
      done_rel = rel;
    end
    if (rel >= 2 && rel < 66) mask_log[rel-2] = alu_mask;
    if (rel == 2) begin
      op_seen = alu_operation;
      opnd1_seen = alu_operand1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    acc_count = 0; ren_count = 0; wr_count = 0; done_count = 0;
    first_wr = -1; last_wr = -1; done_rel = -1;
    mask_log = '0; op_seen = '0; opnd1_seen = '0;
    first_raddr1 = '0; first_raddr3 = '0; last_waddr = '0;
    b2b_acc.delete();
  endtask

  function automatic int a(input int r, input int i);
    return r * 32 + i;
  endfunction

  // Offers one instruction for a single cycle; the sequencer is expected idle.
  task automatic issue(input logic [3:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                       input logic [4:0] vs2, input logic vm, input logic [EW:0] vl,
                       input logic [MAXVL-1:0] mask);
    clear_stats();
    in_op = op; in_vd = vd; in_vs1 = vs1; in_vs2 = vs2;
    in_vm = vm; in_vl = vl; in_mask = mask;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for done, then lets the pipeline settle.
  task automatic wait_done(input string tag);
    for (int k = 0; k < 200 && done_count == 0; k++) tick();
    check({tag, "_done_seen"}, 32'(done_count), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_op = '0; in_vd = '0; in_vs1 = '0; in_vs2 = '0;
    in_vm = 1'b0; in_vl = '0; in_mask = '0;
    for (int i = 0; i < 1024; i++) vrf[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      vrf[a(1, i)]  = 32'(i + 1);
      vrf[a(2, i)]  = 32'd10;
      vrf[a(3, i)]  = 32'h0000_DEAD;
      vrf[a(4, i)]  = 32'd20;
      vrf[a(5, i)]  = 32'd5;
      vrf[a(6, i)]  = 32'hAAAA_AAAA;
      vrf[a(8, i)]  = 32'(i);
      vrf[a(9, i)]  = 32'd1;
      vrf[a(11, i)] = 32'h8000_0000;
      vrf[a(12, i)] = 32'd4;
      vrf[a(14, i)] = 32'h77;
      vrf[a(15, i)] = 32'h1234_5678 + 32'(i) * 32'h11;
      vrf[a(16, i)] = 32'h0F;
      vrf[a(17, i)] = 32'h33;
    end
    clear_stats();
    tick(); tick(); tick();

    // Reset state.
    check("rst_ren", 32'(rf_ren), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_opnd1", alu_operand1, 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);
    tick();

    // Unmasked vadd, vl=4.
    issue(4'd0, 5'd3, 5'd1, 5'd2, 1'b1, 6'd4, '0);
    check("vadd_busy", 32'(busy), 32'd1);
    check("vadd_ready_busy", 32'(in_ready), 32'd0);
    wait_done("vadd");
    check("vadd_wr_count", 32'(wr_count), 32'd4);
    check("vadd_first_wr", 32'(first_wr), 32'd3);
    check("vadd_last_wr", 32'(last_wr), 32'd6);
    check("vadd_done_cyc", 32'(done_rel), 32'd7);
    check("vadd_raddr1", 32'(first_raddr1), 32'd32);
    check("vadd_raddr3", 32'(first_raddr3), 32'd96);
    check("vadd_last_waddr", 32'(last_waddr), 32'd99);
    check("vadd_e0", vrf[a(3, 0)], 32'd11);
    check("vadd_e1", vrf[a(3, 1)], 32'd12);
    check("vadd_e2", vrf[a(3, 2)], 32'd13);
    check("vadd_e3", vrf[a(3, 3)], 32'd14);
    check("vadd_e4_untouched", vrf[a(3, 4)], 32'h0000_DEAD);
    check("vadd_idle_busy", 32'(busy), 32'd0);
    check("vadd_idle_op", 32'(alu_operation), 32'd0);

    // Masked vsub.
    issue(4'd1, 5'd6, 5'd4, 5'd5, 1'b0, 6'd4, 32'h0000_0005);
    wait_done("vsub");
    check("vsub_mask_seq", 32'(mask_log[4:0]), 32'h05);
    check("vsub_e0", vrf[a(6, 0)], 32'd15);
    check("vsub_e1", vrf[a(6, 1)], 32'hAAAA_AAAA);
    check("vsub_e2", vrf[a(6, 2)], 32'd15);
    check("vsub_e3", vrf[a(6, 3)], 32'hAAAA_AAAA);
    check("vsub_e4", vrf[a(6, 4)], 32'hAAAA_AAAA);

    // vl=0.
    issue(4'd0, 5'd7, 5'd1, 5'd2, 1'b1, 6'd0, '0);
    wait_done("vl0");
    check("vl0_ren", 32'(ren_count), 32'd0);
    check("vl0_we", 32'(wr_count), 32'd0);
    check("vl0_done_cyc", 32'(done_rel), 32'd1);
    check("vl0_reg_untouched", vrf[a(7, 0)], 32'd0);

    // vl=40 clamps to 32.
    issue(4'd0, 5'd10, 5'd8, 5'd9, 1'b1, 6'd40, '0);
    wait_done("vl40");
    check("vl40_ren", 32'(ren_count), 32'd32);
    check("vl40_we", 32'(wr_count), 32'd32);
    check("vl40_done_cyc", 32'(done_rel), 32'd35);
    check("vl40_last_waddr", 32'(last_waddr), 32'd351);
    check("vl40_e0", vrf[a(10, 0)], 32'd1);
    check("vl40_e31", vrf[a(10, 31)], 32'd32);

    // Back-to-back vsra, in_valid held until the second accept.
    clear_stats();
    in_op = 4'd7; in_vd = 5'd13; in_vs1 = 5'd11; in_vs2 = 5'd12;
    in_vm = 1'b1; in_vl = 6'd2; in_mask = '0;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && acc_count < 2; k++) tick();
    in_valid = 1'b0;
    for (int k = 0; k < 50 && done_count < 2; k++) tick();
    tick(); tick();
    check("b2b_accepts", 32'(b2b_acc.size()), 32'd2);
    if (b2b_acc.size() == 2)
      check("b2b_gap", 32'(b2b_acc[1] - b2b_acc[0]), 32'd5);
    check("b2b_wr_count", 32'(wr_count), 32'd4);
    check("b2b_done_count", 32'(done_count), 32'd2);
    check("b2b_e0", vrf[a(13, 0)], 32'hF800_0000);
    check("b2b_e1", vrf[a(13, 1)], 32'hF800_0000);
    check("b2b_e2", vrf[a(13, 2)], 32'h0);

    // Reset asserted in cycle 3 of a vl=8 vadd.
    issue(4'd0, 5'd14, 5'd1, 5'd2, 1'b1, 6'd8, '0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_mid_we", 32'(rf_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ren", 32'(rf_ren), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 12; k++) tick();
    check("rst_mid_no_done", 32'(done_count), 32'd0);
    check("rst_mid_wr_count", 32'(wr_count), 32'd1);
    check("rst_mid_e0", vrf[a(14, 0)], 32'd11);
    check("rst_mid_e1", vrf[a(14, 1)], 32'h77);

    // Aliasing vd == vs1, vand with 0x0F.
    issue(4'd2, 5'd15, 5'd15, 5'd16, 1'b1, 6'd8, '0);
    wait_done("alias");
    for (int i = 0; i < 8; i++)
      check($sformatf("alias_e%0d", i), vrf[a(15, i)], 32'(8 + i));
    check("alias_e8_untouched", vrf[a(15, 8)], 32'h1234_5678 + 32'h88);

    // Opcode 9 is forwarded; the ALU returns 0 and that result is written.
    issue(4'd9, 5'd17, 5'd1, 5'd2, 1'b1, 6'd1, '0);
    wait_done("op9");
    check("op9_forward", 32'(op_seen), 32'd9);
    check("op9_opnd1", opnd1_seen, 32'd1);
    check("op9_e0", vrf[a(17, 0)], 32'd0);
    check("op9_e1", vrf[a(17, 1)], 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end
endmodule
